// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared NoC widths and network-interface FSM state encoding
// Optional TSTAMP state exists only when INJ_TIMESTAMP_EN is defined.
package noc_pkg;

  localparam int NOC_TAM_FLIT   = 16;
  localparam int NOC_METADEFLIT = 8;

  typedef enum logic [2:0] {
    NOC_IDLE    = 3'd0,
    NOC_HEADER  = 3'd1,
    NOC_SIZE    = 3'd2,
    NOC_PAYLOAD = 3'd3
`ifdef INJ_TIMESTAMP_EN
    ,
    NOC_TSTAMP  = 3'd4
`endif
  } noc_state_e;

endpackage

// File: rtl/ni_packet_injector.sv
// rtl/ni_packet_injector.sv - builds header/size/payload flits toward a router local port
// Macro INJ_TIMESTAMP_EN adds a cycle counter and a timestamp flit after the size flit.
module ni_packet_injector
  import noc_pkg::*;
#(
  parameter int TAM_FLIT   = NOC_TAM_FLIT,
  parameter int METADEFLIT = NOC_METADEFLIT,
  parameter int MAX_LEN    = 255
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [2*METADEFLIT-1:0] cmd_dest,
  input  logic [TAM_FLIT-1:0]     cmd_len,
  input  logic                    pay_valid,
  output logic                    pay_ready,
  input  logic [TAM_FLIT-1:0]     pay_data,
  output logic                    tx,
  output logic [TAM_FLIT-1:0]     data_out,
  input  logic                    credit_i,
  output logic                    busy
);

  localparam logic [TAM_FLIT-1:0] MAX_LEN_W = TAM_FLIT'(MAX_LEN);

  noc_state_e                state_q, state_d;
  logic [2*METADEFLIT-1:0]   dest_q;
  logic [TAM_FLIT-1:0]       len_q;
  logic [TAM_FLIT-1:0]       remaining_q;
  logic [TAM_FLIT-1:0]       len_sat;
  logic [TAM_FLIT-1:0]       size_flit;
  logic                      accept;

`ifdef INJ_TIMESTAMP_EN
  logic [TAM_FLIT-1:0]       tstamp_cnt_q;
  logic [TAM_FLIT-1:0]       tstamp_q;
`endif

  assign len_sat = (cmd_len > MAX_LEN_W) ? MAX_LEN_W : cmd_len;
  assign accept  = (state_q == NOC_IDLE) && cmd_valid;

`ifdef INJ_TIMESTAMP_EN
  // The size flit counts the timestamp flit as part of the packet body.
  assign size_flit = len_q + TAM_FLIT'(1);
`else
  assign size_flit = len_q;
`endif

  always_comb begin
    state_d   = state_q;
    tx        = 1'b0;
    data_out  = '0;
    cmd_ready = 1'b0;
    pay_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      NOC_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) state_d = NOC_HEADER;
      end
      NOC_HEADER: begin
        tx       = 1'b1;
        data_out = TAM_FLIT'(dest_q);
        if (credit_i) state_d = NOC_SIZE;
      end
      NOC_SIZE: begin
        tx       = 1'b1;
        data_out = size_flit;
        if (credit_i) begin
`ifdef INJ_TIMESTAMP_EN
          state_d = NOC_TSTAMP;
`else
          state_d = (len_q == '0) ? NOC_IDLE : NOC_PAYLOAD;
`endif
        end
      end
`ifdef INJ_TIMESTAMP_EN
      NOC_TSTAMP: begin
        tx       = 1'b1;
        data_out = tstamp_q;
        if (credit_i) state_d = (len_q == '0) ? NOC_IDLE : NOC_PAYLOAD;
      end
`endif
      NOC_PAYLOAD: begin
        tx        = pay_valid;
        data_out  = pay_data;
        pay_ready = pay_valid & credit_i;
        if (pay_ready && remaining_q == TAM_FLIT'(1)) state_d = NOC_IDLE;
      end
      default: begin
        state_d = NOC_IDLE;
        busy    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= NOC_IDLE;
      dest_q      <= '0;
      len_q       <= '0;
      remaining_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dest_q      <= cmd_dest;
        len_q       <= len_sat;
        remaining_q <= len_sat;
      end else if (state_q == NOC_PAYLOAD && pay_ready) begin
        remaining_q <= remaining_q - TAM_FLIT'(1);
      end
    end
  end

`ifdef INJ_TIMESTAMP_EN
  // Free-running counter; the value seen in the accept cycle becomes the timestamp.
  always_ff @(posedge clock) begin
    if (reset) begin
      tstamp_cnt_q <= '0;
      tstamp_q     <= '0;
    end else begin
      tstamp_cnt_q <= tstamp_cnt_q + TAM_FLIT'(1);
      if (accept) tstamp_q <= tstamp_cnt_q;
    end
  end
`endif

endmodule

// File: tb/tb_ni_packet_injector.sv
// tb/tb_ni_packet_injector.sv - scoreboard bench for ni_packet_injector
// Honours INJ_TIMESTAMP_EN when the design is built with it.
module tb_ni_packet_injector;

  localparam int TAM_FLIT   = 16;
  localparam int METADEFLIT = 8;
  localparam int MAX_LEN    = 255;
`ifdef INJ_TIMESTAMP_EN
  localparam int TS = 1;
`else
  localparam int TS = 0;
`endif

  logic                    clock = 1'b0;
  logic                    reset;
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [2*METADEFLIT-1:0] cmd_dest;
  logic [TAM_FLIT-1:0]     cmd_len;
  logic                    pay_valid;
  logic                    pay_ready;
  logic [TAM_FLIT-1:0]     pay_data;
  logic                    tx;
  logic [TAM_FLIT-1:0]     data_out;
  logic                    credit_i;
  logic                    busy;

  ni_packet_injector #(
    .TAM_FLIT(TAM_FLIT), .METADEFLIT(METADEFLIT), .MAX_LEN(MAX_LEN)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .pay_valid(pay_valid), .pay_ready(pay_ready), .pay_data(pay_data),
    .tx(tx), .data_out(data_out), .credit_i(credit_i), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [TAM_FLIT-1:0] data;
    bit                  is_pay;
  } flit_t;

  flit_t               exp_q[$];
  logic [TAM_FLIT-1:0] pay_q[$];
  int errors = 0;
  int checks = 0;
  int xfer_cnt = 0;
  int stall_cnt = 0;
  int credit_mode = 0;
  int pay_pct = 100;
`ifdef INJ_TIMESTAMP_EN
  logic [TAM_FLIT-1:0] tb_cnt;
  always @(posedge clock) tb_cnt <= reset ? '0 : tb_cnt + 16'd1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare DUT outputs against the head of the expected-flit queue.
  always @(negedge clock) begin
    if (!reset) begin
      if (exp_q.size() == 0) begin
        chk("idle_tx", tx, 0);
        chk("idle_data", data_out, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("idle_pay_ready", pay_ready, 0);
      end else begin
        chk("busy", busy, 1);
        chk("cmd_ready", cmd_ready, 0);
        chk("tx", tx, exp_q[0].is_pay ? pay_valid : 1'b1);
        chk("pay_ready", pay_ready, tx && credit_i && exp_q[0].is_pay);
        if (tx) begin
          chk("data_out", data_out, exp_q[0].data);
          if (credit_i) begin
            void'(exp_q.pop_front());
            xfer_cnt++;
          end else begin
            stall_cnt++;
          end
        end
      end
    end
  end

  initial begin
    bit cons;
    pay_valid = 1'b0;
    pay_data  = '0;
    forever begin
      @(negedge clock);
      cons = pay_ready && !reset;
      @(posedge clock);
      #2;
      if (cons && pay_q.size() > 0) void'(pay_q.pop_front());
      if (pay_q.size() > 0 && $urandom_range(99) < pay_pct) begin
        pay_valid = 1'b1;
        pay_data  = pay_q[0];
      end else begin
        pay_valid = 1'b0;
        pay_data  = TAM_FLIT'($urandom);
      end
    end
  end

  initial begin
    credit_i = 1'b1;
    forever begin
      @(posedge clock);
      #2;
      if (credit_mode == 0) credit_i = 1'b1;
      else if (credit_mode == 2) credit_i = 1'b0;
      else credit_i = ($urandom_range(99) < 60);
    end
  end

  task automatic send(input logic [15:0] dest, input int len, input logic [15:0] base);
    bit ok;
    int sat;
    logic [TAM_FLIT-1:0] w;
`ifdef INJ_TIMESTAMP_EN
    logic [TAM_FLIT-1:0] ts;
    ts = '0;
`endif
    @(posedge clock);
    #1;
    cmd_valid = 1'b1;
    cmd_dest  = dest;
    cmd_len   = len[15:0];
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (cmd_ready) begin
        ok = 1'b1;
`ifdef INJ_TIMESTAMP_EN
        ts = tb_cnt;
`endif
        break;
      end
    end
    chk("accept_timeout", ok, 1);
    @(posedge clock);
    #1;
    cmd_valid = 1'b0;
    if (ok) begin
      sat = (len > MAX_LEN) ? MAX_LEN : len;
      exp_q.push_back('{data: dest, is_pay: 1'b0});
      w = TAM_FLIT'(sat + TS);
      exp_q.push_back('{data: w, is_pay: 1'b0});
`ifdef INJ_TIMESTAMP_EN
      exp_q.push_back('{data: ts, is_pay: 1'b0});
`endif
      for (int i = 0; i < sat; i++) begin
        w = base + TAM_FLIT'(i);
        exp_q.push_back('{data: w, is_pay: 1'b1});
        pay_q.push_back(w);
      end
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_timeout", done, 1);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    exp_q.delete();
    pay_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int x0, s0;
    bit hit;
    int len;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_dest = '0;
    cmd_len = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    #1;
    chk("rst_tx", tx, 0);
    chk("rst_data", data_out, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_pay_ready", pay_ready, 0);

    // Full-rate packet: consecutive flits, busy drops right after the last one.
    credit_mode = 0;
    pay_pct = 100;
    x0 = xfer_cnt;
    send(16'h0102, 3, 16'h00A1);
    repeat (5 + TS) @(posedge clock);
    @(negedge clock);
    #1;
    chk("s1_flit_count", xfer_cnt - x0, 5 + TS);
    chk("s1_busy_after", busy, 0);

    // Credit withheld for three cycles while the size flit is presented.
    x0 = xfer_cnt;
    s0 = stall_cnt;
    send(16'h0102, 3, 16'h00A1);
    @(posedge clock);
    #1;
    credit_mode = 2;
    repeat (3) @(posedge clock);
    #1;
    credit_mode = 0;
    drain();
    chk("s2_stall_cycles", stall_cnt - s0, 3);
    chk("s2_flit_count", xfer_cnt - x0, 5 + TS);

    x0 = xfer_cnt;
    send(16'h0102, 0, 16'h0000);
    drain();
    chk("s3_zero_len_flits", xfer_cnt - x0, 2 + TS);

    // Reset in the middle of a payload drops the packet.
    send(16'h0304, 5, 16'h0050);
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      #1;
      if (exp_q.size() == 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk("s4_reach_mid", hit, 1);
    do_reset();
    @(negedge clock);
    #1;
    chk("s4_tx_after_rst", tx, 0);
    chk("s4_cmd_ready_after_rst", cmd_ready, 1);
    x0 = xfer_cnt;
    send(16'h0304, 1, 16'h0077);
    drain();
    chk("s4_new_packet_flits", xfer_cnt - x0, 3 + TS);

    x0 = xfer_cnt;
    send(16'h0506, 300, 16'h1000);
    drain();
    chk("s5_saturated_flits", xfer_cnt - x0, 257 + TS);

    for (int n = 0; n < 40; n++) begin
      credit_mode = $urandom_range(0, 1);
      pay_pct = $urandom_range(30, 100);
      len = ($urandom_range(9) == 0) ? $urandom_range(256, 400) : $urandom_range(0, 10);
      send(16'($urandom), len, 16'($urandom));
    end
    drain();
    credit_mode = 0;
    repeat (3) @(posedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/ni_packet_injector.md
NI_PACKET_INJECTOR -- requirements
Module: ni_packet_injector

Interface
REQ-001 Parameter TAM_FLIT, default 16: flit width in bits.
REQ-002 Parameter METADEFLIT, default 8: width of each X/Y address field; the destination field is 2*METADEFLIT wide and SHALL NOT exceed TAM_FLIT.
REQ-003 Parameter MAX_LEN, default 255: largest accepted payload length in flits.
REQ-004 clock  in  1  the single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 cmd_valid  in  1  packet request valid.
REQ-007 cmd_ready  out  1  injector can accept a request.
REQ-008 cmd_dest  in  2*METADEFLIT  target address {X,Y}.
REQ-009 cmd_len  in  TAM_FLIT  payload length in flits, 0..MAX_LEN.
REQ-010 pay_valid  in  1  payload word valid.
REQ-011 pay_ready  out  1  injector consumes the payload word this cycle.
REQ-012 pay_data  in  TAM_FLIT  payload word.
REQ-013 tx  out  1  flit valid toward the router local port (the rx input of that port).
REQ-014 data_out  out  TAM_FLIT  flit toward the router local port.
REQ-015 credit_i  in  1  router local credit (credit_o of that port); the flit transfers in a cycle where tx=1 and credit_i=1.
REQ-016 busy  out  1  a packet is in progress.

Function
REQ-017 The FSM SHALL have the states IDLE, HEADER, SIZE and PAYLOAD.
REQ-018 IDLE: cmd_ready=1 and tx=0; when cmd_valid=1, latch cmd_dest and cmd_len, then go to HEADER.
REQ-019 HEADER: tx=1 and data_out is cmd_dest zero-extended to TAM_FLIT; on transfer go to SIZE.
REQ-020 SIZE: tx=1 and data_out is the latched length (plus 1 if INJ_TIMESTAMP_EN is defined); on transfer go to PAYLOAD, or to IDLE if the size flit is 0.
REQ-021 PAYLOAD: tx=pay_valid, data_out=pay_data and pay_ready=tx&credit_i.
REQ-022 Each payload transfer decrements a remaining-flit counter.
REQ-023 After the transfer that leaves 0 flits remaining, go to IDLE.
REQ-024 Stall: while tx=1 and credit_i=0, data_out and the state SHALL hold unchanged, and pay_ready=0.
REQ-025 tx SHALL NOT deassert in HEADER or SIZE before the flit transfers.
REQ-026 Minimum latency: the header flit appears on the cycle after cmd accept, giving back-to-back flits at one per cycle when credit_i=1.
REQ-027 cmd_ready=0 in every state except IDLE; a request arriving in the same cycle as the final flit transfer is accepted one cycle later (IDLE).
REQ-028 If cmd_len>MAX_LEN, latch MAX_LEN instead (saturate).
REQ-029 busy=1 in every state except IDLE.
REQ-030 pay_ready=0 outside PAYLOAD.

Reset
REQ-031 reset=1 at a rising edge SHALL force IDLE, clear the counter and latched fields, and force tx=0, data_out=0, cmd_ready=1 (after release), pay_ready=0 and busy=0.
REQ-032 Reset mid-packet SHALL drop the packet; no flit is emitted in the cycle after reset.

Configuration
REQ-033 The feature is controlled by the macro INJ_TIMESTAMP_EN.
REQ-034 With INJ_TIMESTAMP_EN defined: a free-running TAM_FLIT-bit cycle counter runs (cleared by reset, wraps at 2^TAM_FLIT).
REQ-035 With INJ_TIMESTAMP_EN defined: a TSTAMP state between SIZE and PAYLOAD emits the counter value captured at cmd accept.
REQ-036 With INJ_TIMESTAMP_EN defined: the size flit counts the timestamp flit, and len=0 yields SIZE->TSTAMP->IDLE.
REQ-037 Without INJ_TIMESTAMP_EN: no counter and no TSTAMP state; the behaviour is exactly as in REQ-017..030.

Structure
REQ-038 A shared package noc_pkg SHALL hold the TAM_FLIT/METADEFLIT defaults and the FSM state encoding, reused by a later ejector block.
REQ-039 The block is a single module with no sub-module.

Verification
REQ-040 Scenario: cmd dest=0x0102, len=3, payload 0xA1,0xA2,0xA3, credit_i=1 -> data_out 0x0102,0x0003,0xA1,0xA2,0xA3 on 5 consecutive cycles; busy falls after the last flit.
REQ-041 Scenario: same packet with credit_i=0 for cycles 2-4 -> the size flit holds for 3 cycles with tx=1, no flit is lost or duplicated, and pay_ready=0 during the stall.
REQ-042 Scenario: len=0 -> exactly 2 flits (0x0102, 0x0000), then IDLE; pay_ready is never 1.
REQ-043 Scenario: reset asserted after the 2nd payload flit of len=5 -> next cycle tx=0 and cmd_ready=1; a new len=1 packet then completes correctly.
REQ-044 Scenario: cmd_len=300 with MAX_LEN=255 -> size flit 0x00FF and 255 payload flits.
REQ-045 Scenario (INJ_TIMESTAMP_EN defined): cmd accepted at counter=0x0010, len=2 -> flits dest, 0x0003, 0x0010, p0, p1.
